// File: rtl/lockpick_input_debounce.sv
// Button conditioning for the lockpick game: 2-flop sync, prescaled-tick debounce, press/release pulses.
// Define LOCKPICK_AUTOREPEAT_EN to turn a held button into repeated press pulses.
module lockpick_input_debounce #(
   parameter int NUM_BTN      = 4,
   parameter int PRESCALE     = 1000,
   parameter int STABLE_CNT   = 4,
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic               any_press
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int CW = $clog2(STABLE_CNT + 1);
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT - 1);

   if (PRESCALE < 2 || STABLE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
      $error("lockpick_input_debounce: illegal parameter value");
   end

   logic [NUM_BTN-1:0]         r_sync1;
   logic [NUM_BTN-1:0]         r_sync2;
   logic [PW-1:0]              r_pre;
   logic [NUM_BTN-1:0][CW-1:0] r_cnt;
   logic [NUM_BTN-1:0]         r_level;
   logic [NUM_BTN-1:0]         r_press;
   logic [NUM_BTN-1:0]         r_release;
   logic                       r_any;

   logic                       w_tick;
   logic [NUM_BTN-1:0][CW-1:0] w_cnt_nxt;
   logic [NUM_BTN-1:0]         w_rise;
   logic [NUM_BTN-1:0]         w_fall;
   logic [NUM_BTN-1:0]         w_rep_fire;

   // Synchronizer keeps running while disabled so re-enable sees a fresh input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= btn_in;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre <= '0;
      end else if (ena) begin
         r_pre <= (r_pre == PRE_MAX) ? '0 : r_pre + PW'(1);
      end
   end

   assign w_tick = ena && (r_pre == PRE_MAX);

   always_comb begin
      w_cnt_nxt = r_cnt;
      w_rise    = '0;
      w_fall    = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (w_tick) begin
            if (r_sync2[i] == r_level[i]) begin
               w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] == CNT_MAX) begin
               w_cnt_nxt[i] = '0;
               w_rise[i]    = ~r_level[i];
               w_fall[i]    = r_level[i];
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + CW'(1);
            end
         end
      end
   end

`ifdef LOCKPICK_AUTOREPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);
   localparam logic [RW-1:0] R_DLY  = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] R_RATE = RW'(REPEAT_RATE);

   logic [NUM_BTN-1:0][RW-1:0] r_rep;
   logic [NUM_BTN-1:0][RW-1:0] w_rep_nxt;

   // A release on the same tick a repeat falls due wins: no press alongside a release.
   always_comb begin
      w_rep_nxt  = r_rep;
      w_rep_fire = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (w_rise[i]) begin
            w_rep_nxt[i] = R_DLY;
         end else if (w_fall[i]) begin
            w_rep_nxt[i] = '0;
         end else if (w_tick && r_level[i] && (r_rep[i] != '0)) begin
            if (r_rep[i] == RW'(1)) begin
               w_rep_fire[i] = 1'b1;
               w_rep_nxt[i]  = R_RATE;
            end else begin
               w_rep_nxt[i] = r_rep[i] - RW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rep <= '0;
      end else begin
         r_rep <= w_rep_nxt;
      end
   end
`else
   assign w_rep_fire = '0;
`endif

   // Pulses are only ever set on a tick, so they self-clear on the next cycle (including ena low).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_level   <= '0;
         r_press   <= '0;
         r_release <= '0;
         r_any     <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_level   <= r_level ^ (w_rise | w_fall);
         r_press   <= w_rise | w_rep_fire;
         r_release <= w_fall;
         r_any     <= |(w_rise | w_rep_fire);
      end
   end

   assign btn_level   = r_level;
   assign btn_press   = r_press;
   assign btn_release = r_release;
   assign any_press   = r_any;

endmodule

// File: tb/tb_lockpick_input_debounce.sv
// Bench for lockpick_input_debounce: directed scenarios plus random traffic against a tick-level model.
// Expectations for auto-repeat follow LOCKPICK_AUTOREPEAT_EN.
module tb_lockpick_input_debounce;

   localparam int NB  = 4;
   localparam int PRE = 4;
   localparam int STB = 3;
   localparam int RD  = 5;
   localparam int RR  = 2;
`ifdef LOCKPICK_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          ena   = 1'b1;
   logic [NB-1:0] btn_in = '0;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_release;
   logic          any_press;

   int total = 0;
   int bad   = 0;

   lockpick_input_debounce #(
      .NUM_BTN(NB), .PRESCALE(PRE), .STABLE_CNT(STB),
      .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .btn_in(btn_in),
      .btn_level(btn_level), .btn_press(btn_press),
      .btn_release(btn_release), .any_press(any_press)
   );

   always #5 clk = ~clk;

   // Reference: input seen two edges late, ticks every PRE enabled cycles,
   // level flips after STB consecutive disagreeing ticks, repeats counted in ticks since press.
   int            m_pre;
   logic [NB-1:0] m_h1, m_h2, m_lvl, m_press, m_rel;
   logic          m_any;
   int            m_run  [NB];
   int            m_held [NB];

   task automatic step();
      logic [NB-1:0] syn;
      bit tk, fl;
      @(posedge clk);
      if (!rst_n) begin
         m_pre = 0; m_h1 = '0; m_h2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
         for (int c = 0; c < NB; c++) begin
            m_run[c]  = 0;
            m_held[c] = -1;
         end
      end else begin
         syn  = m_h2;
         m_h2 = m_h1;
         m_h1 = btn_in;
         tk   = ena && (m_pre == PRE - 1);
         if (ena) m_pre = (m_pre + 1) % PRE;
         m_press = '0;
         m_rel   = '0;
         if (tk) begin
            for (int c = 0; c < NB; c++) begin
               fl = 1'b0;
               if (syn[c] != m_lvl[c]) begin
                  m_run[c]++;
                  if (m_run[c] == STB) begin
                     m_run[c] = 0;
                     fl = 1'b1;
                     m_lvl[c] = ~m_lvl[c];
                     if (m_lvl[c]) begin
                        m_press[c] = 1'b1;
                        m_held[c]  = 0;
                     end else begin
                        m_rel[c]  = 1'b1;
                        m_held[c] = -1;
                     end
                  end
               end else begin
                  m_run[c] = 0;
               end
               if (AR && !fl && m_lvl[c]) begin
                  m_held[c]++;
                  if (m_held[c] == RD || (m_held[c] > RD && (m_held[c] - RD) % RR == 0))
                     m_press[c] = 1'b1;
               end
            end
         end
      end
      m_any = |m_press;
      #1;
   endtask

   task automatic test_reset();
      int rise_at = -1;
      int npress = 0, nany = 0, nrel = 0;
      logic [NB-1:0] pval = '0, rval = '0;
      rst_n = 1'b0; btn_in = 4'hF; ena = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if ({btn_level, btn_press, btn_release, any_press} !== 13'd0) begin
            bad++;
            $display("FAIL reset_hold: got lvl=%h prs=%h rel=%h any=%b, want all 0",
                     btn_level, btn_press, btn_release, any_press);
         end
      end
      rst_n = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         step();
         if (btn_press != '0) begin npress++; pval = btn_press; end
         if (any_press) nany++;
         if (rise_at < 0 && btn_level == 4'hF) begin
            rise_at = i;
            total++;
            if (btn_press !== 4'hF) begin
               bad++;
               $display("FAIL reset_press_align: got prs=%h at level rise, want F", btn_press);
            end
         end
      end
      total++;
      if (rise_at != 12) begin
         bad++;
         $display("FAIL reset_latency: got %0d cycles, want 12", rise_at);
      end
      total++;
      if (npress != 1 || pval !== 4'hF || nany != 1) begin
         bad++;
         $display("FAIL reset_press_count: got %0d pulses val=%h any=%0d, want 1 val=F any=1",
                  npress, pval, nany);
      end
      btn_in = '0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (btn_release != '0) begin nrel++; rval = btn_release; end
      end
      total++;
      if (nrel != 1 || rval !== 4'hF || btn_level !== 4'h0) begin
         bad++;
         $display("FAIL reset_release: got %0d pulses val=%h lvl=%h, want 1 val=F lvl=0",
                  nrel, rval, btn_level);
      end
   endtask

   task automatic test_clean_press();
      int rise_at = -1, npress = 0, nany = 0;
      btn_in[0] = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (btn_press[0]) npress++;
         if (any_press) nany++;
         if (rise_at >= 0) begin
            total++;
            if (btn_press[0] !== 1'b0 || any_press !== 1'b0) begin
               bad++;
               $display("FAIL press_width: got prs=%b any=%b after pulse, want 0 0",
                        btn_press[0], any_press);
            end
            break;
         end
         if (btn_level[0]) begin
            rise_at = i;
            total++;
            if (btn_press[0] !== 1'b1 || any_press !== 1'b1) begin
               bad++;
               $display("FAIL press_align: got prs=%b any=%b at rise, want 1 1",
                        btn_press[0], any_press);
            end
         end
      end
      total++;
      if (rise_at < 1 || rise_at > 15) begin
         bad++;
         $display("FAIL press_latency: got %0d cycles, want 1..15", rise_at);
      end
      total++;
      if (npress != 1 || nany != 1) begin
         bad++;
         $display("FAIL press_count: got prs=%0d any=%0d, want 1 1", npress, nany);
      end
   endtask

   task automatic test_release();
      int fall_at = -1, nrel = 0, npress = 0;
      btn_in[0] = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (btn_release[0]) nrel++;
         if (btn_press != '0) npress++;
         if (fall_at < 0 && !btn_level[0]) fall_at = i;
      end
      total++;
      if (fall_at < 1 || fall_at > 15) begin
         bad++;
         $display("FAIL release_latency: got %0d cycles, want 1..15", fall_at);
      end
      total++;
      if (nrel != 1 || npress != 0 || btn_level[0] !== 1'b0) begin
         bad++;
         $display("FAIL release_pulses: got rel=%0d prs=%0d lvl=%b, want 1 0 0",
                  nrel, npress, btn_level[0]);
      end
   endtask

   task automatic test_bounce();
      int hi = 0, np = 0;
      for (int i = 0; i < 80; i++) begin
         if (i < 60 && i % 3 == 0) btn_in[1] = ~btn_in[1];
         if (i == 60) btn_in[1] = 1'b0;
         step();
         if (btn_level[1]) hi++;
         if (btn_press[1] || btn_release[1]) np++;
      end
      total++;
      if (hi != 0 || np != 0) begin
         bad++;
         $display("FAIL bounce_reject: got %0d high cycles %0d pulses, want 0 0", hi, np);
      end
   endtask

   task automatic test_enable_freeze();
      logic [NB-1:0] lvl0;
      int chg = 0, np = 0, rise_at = -1, npress = 0;
      ena = 1'b0;
      btn_in[2] = 1'b1;
      lvl0 = btn_level;
      for (int i = 0; i < 100; i++) begin
         step();
         if (btn_level !== lvl0) chg++;
         if (btn_press != '0 || btn_release != '0 || any_press) np++;
      end
      total++;
      if (chg != 0 || np != 0) begin
         bad++;
         $display("FAIL freeze_hold: got %0d level changes %0d pulses, want 0 0", chg, np);
      end
      ena = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (btn_press[2]) npress++;
         if (rise_at >= 0) break;
         if (btn_level[2]) rise_at = i;
      end
      total++;
      if (rise_at < 1 || rise_at > 15 || npress != 1) begin
         bad++;
         $display("FAIL freeze_resume: got rise at %0d with %0d pulses, want 1..15 and 1",
                  rise_at, npress);
      end
      btn_in[2] = 1'b0;
      repeat (20) step();
      total++;
      if (btn_level !== 4'h0) begin
         bad++;
         $display("FAIL freeze_release: got lvl=%h, want 0", btn_level);
      end
   endtask

   task automatic test_autorepeat();
      int rise_at = -1, npress = 0, first_rep = -1;
      int want_n = AR ? 9 : 1;
      int want_first = AR ? RD * PRE : -1;
      btn_in[3] = 1'b1;
      for (int i = 1; i <= 20 && rise_at < 0; i++) begin
         step();
         if (btn_press[3]) npress++;
         if (btn_level[3]) rise_at = i;
      end
      for (int k = 1; k <= 20 * PRE; k++) begin
         step();
         if (btn_press[3]) begin
            npress++;
            if (first_rep < 0) first_rep = k;
         end
      end
      total++;
      if (npress != want_n) begin
         bad++;
         $display("FAIL repeat_count: got %0d pulses, want %0d", npress, want_n);
      end
      total++;
      if (first_rep != want_first) begin
         bad++;
         $display("FAIL repeat_first: got offset %0d, want %0d", first_rep, want_first);
      end
      btn_in[3] = 1'b0;
      repeat (30) step();
   endtask

   task automatic test_random();
      int hold [NB];
      for (int c = 0; c < NB; c++) hold[c] = $urandom_range(1, 40);
      for (int n = 0; n < 1500; n++) begin
         step();
         total++;
         if ({btn_level, btn_press, btn_release, any_press} !== {m_lvl, m_press, m_rel, m_any}) begin
            bad++;
            $display("FAIL random cyc %0d: got lvl=%h prs=%h rel=%h any=%b, want lvl=%h prs=%h rel=%h any=%b",
                     n, btn_level, btn_press, btn_release, any_press, m_lvl, m_press, m_rel, m_any);
         end
         for (int c = 0; c < NB; c++) begin
            hold[c] = hold[c] - 1;
            if (hold[c] == 0) begin
               btn_in[c] = ~btn_in[c];
               hold[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : $urandom_range(10, 70);
            end
         end
         if (ena) begin
            if ($urandom_range(0, 99) < 2) ena = 1'b0;
         end else if ($urandom_range(0, 9) == 0) begin
            ena = 1'b1;
         end
         rst_n = !(n >= 700 && n < 703);
      end
      rst_n = 1'b1;
      ena = 1'b1;
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_release();
      test_bounce();
      test_enable_freeze();
      test_autorepeat();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
